// File: rtl/dom_mask_pkg.sv
// Shared constants and types for the DOM AND gadget masking front end.
// Holds the PRNG defaults, FSM state type and the share-pair type.
package dom_mask_pkg;

    localparam int          LFSR_W_DEF = 32;
    // Galois mask for x^32 + x^22 + x^2 + x + 1 in a right-shifting register
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] SEED_DEF   = 32'hACE1_2468;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    typedef logic [1:0] share_t;

    function automatic share_t mask_bit(input logic x, input logic m);
        return {x ^ m, m};
    endfunction

endpackage

// File: rtl/dom_lfsr.sv
// Galois LFSR with seed load, xor-load reseed (zero-guarded) and a
// single- or triple-step advance per enabled cycle.
module dom_lfsr
    import dom_mask_pkg::*;
#(
    parameter int           W    = LFSR_W_DEF,
    parameter logic [W-1:0] SEED = W'(SEED_DEF),
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS)
) (
    input  logic         clk,
    input  logic         load,
    input  logic         xor_load,
    input  logic [W-1:0] xor_data,
    input  logic         step_en,
    input  logic         step3,
    output logic [W-1:0] state
);

    function automatic logic [W-1:0] step(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    logic [W-1:0] one_step;
    logic [W-1:0] three_step;
    logic [W-1:0] xored;

    always_comb begin
        one_step   = step(state);
        three_step = step(step(one_step));
        xored      = state ^ xor_data;
    end

    // An all-zero state would lock the register, so a zero reseed falls back to SEED
    always_ff @(posedge clk) begin
        if (load) begin
            state <= SEED;
        end else if (xor_load) begin
            state <= (xored == '0) ? SEED : xored;
        end else if (step_en) begin
            state <= step3 ? three_step : one_step;
        end
    end

endmodule

// File: rtl/dom_mask_feeder.sv
// Splits operand bits a/b into Boolean share pairs plus a refresh bit for the DOM gadget.
// Optional reseed port pair enabled by defining DOM_MASK_FEEDER_RESEED_EN.
module dom_mask_feeder
    import dom_mask_pkg::*;
#(
    parameter int                LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(SEED_DEF),
    parameter int                WARMUP = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a,
    input  logic              in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        port_a,
    output logic [1:0]        port_b,
    output logic              port_r
`ifdef DOM_MASK_FEEDER_RESEED_EN
    ,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data
`endif
);

    fsm_t              state;
    fsm_t              state_next;
    logic [7:0]        warm_cnt;
    logic [7:0]        warm_cnt_next;
    logic              warm_done;
    logic              reseed;
    logic [LFSR_W-1:0] reseed_data;
    logic              accept;
    logic              lfsr_step;
    logic              lfsr_step3;
    logic [LFSR_W-1:0] lfsr_state;
    logic [LFSR_W-4:0] unused_lfsr_bits;

`ifdef DOM_MASK_FEEDER_RESEED_EN
    assign reseed      = seed_valid;
    assign reseed_data = seed_data;
`else
    assign reseed      = 1'b0;
    assign reseed_data = '0;
`endif

    assign warm_done        = (warm_cnt == 8'(WARMUP - 1));
    assign unused_lfsr_bits = lfsr_state[LFSR_W-1:3];

    dom_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .load     (rst),
        .xor_load (reseed),
        .xor_data (reseed_data),
        .step_en  (lfsr_step),
        .step3    (lfsr_step3),
        .state    (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WARM;
            warm_cnt <= '0;
        end else begin
            state    <= state_next;
            warm_cnt <= warm_cnt_next;
        end
    end

    // A reseed pre-empts everything, including an accept in the same cycle
    always_comb begin
        state_next    = state;
        warm_cnt_next = warm_cnt;
        lfsr_step     = 1'b0;
        lfsr_step3    = 1'b0;
        in_ready      = 1'b0;
        if (reseed) begin
            state_next    = WARM;
            warm_cnt_next = '0;
        end else begin
            case (state)
                WARM: begin
                    lfsr_step     = 1'b1;
                    warm_cnt_next = warm_cnt + 8'd1;
                    if (warm_done) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    in_ready   = !out_valid || out_ready;
                    lfsr_step  = in_valid && in_ready;
                    lfsr_step3 = 1'b1;
                end
                default: state_next = WARM;
            endcase
        end
        accept = in_valid && in_ready;
    end

    // Shares are left in place when the item drains to avoid extra toggling
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            port_a    <= '0;
            port_b    <= '0;
            port_r    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            port_a    <= mask_bit(in_a, lfsr_state[0]);
            port_b    <= mask_bit(in_b, lfsr_state[1]);
            port_r    <= lfsr_state[2];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dom_mask_feeder.sv
// Randomized directed bench for dom_mask_feeder against a cycle-level reference model.
// Reseed steps are included when DOM_MASK_FEEDER_RESEED_EN is defined.
module tb_dom_mask_feeder;

    localparam int          WARMUP = 64;
    localparam logic [31:0] SEED   = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_a;
    logic        in_b;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  port_a;
    logic [1:0]  port_b;
    logic        port_r;
    logic        seed_valid;
    logic [31:0] seed_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lfsr;
    int          m_since;
    logic        m_valid;
    logic [1:0]  m_a;
    logic [1:0]  m_b;
    logic        m_r;
    logic        m_plain_a;
    logic        m_plain_b;
    logic        exp_rdy;
    int          cyc;
    int          first_ready;

    always #5 clk = ~clk;

    dom_mask_feeder #(
        .LFSR_W (32),
        .SEED   (SEED),
        .WARMUP (WARMUP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .port_a     (port_a),
        .port_b     (port_b),
        .port_r     (port_r)
`ifdef DOM_MASK_FEEDER_RESEED_EN
        ,
        .seed_valid (seed_valid),
        .seed_data  (seed_data)
`endif
    );

    // One PRNG step built directly from the polynomial's exponents
    function automatic logic [31:0] prng_next(input logic [31:0] s);
        logic [31:0] poly;
        int          ex [4];
        poly = 32'h0;
        ex   = '{32, 22, 2, 1};
        for (int i = 0; i < 4; i++) poly[ex[i]-1] = 1'b1;
        return (s >> 1) ^ (s[0] ? poly : 32'h0);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic a, input logic b,
                                  input logic ordy, input logic sv, input logic [31:0] sd);
        logic [31:0] tmp;
        rst        = r;
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        out_ready  = ordy;
        seed_valid = sv;
        seed_data  = sd;
        #1;
        exp_rdy = (m_since >= WARMUP) && !sv && (!m_valid || ordy);
        check_output("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        if (in_ready === 1'b1 && first_ready < 0) first_ready = cyc;
        @(posedge clk);
        if (r) begin
            m_lfsr      = SEED;
            m_since     = 0;
            m_valid     = 1'b0;
            m_a         = 2'b00;
            m_b         = 2'b00;
            m_r         = 1'b0;
            cyc         = 0;
            first_ready = -1;
        end else begin
            cyc++;
            if (sv) begin
                tmp     = m_lfsr ^ sd;
                m_lfsr  = (tmp == 32'h0) ? SEED : tmp;
                m_since = 0;
                if (ordy) m_valid = 1'b0;
            end else if (m_since < WARMUP) begin
                m_lfsr = prng_next(m_lfsr);
                m_since++;
                if (ordy) m_valid = 1'b0;
            end else if (exp_rdy && v) begin
                m_a       = {a ^ m_lfsr[0], m_lfsr[0]};
                m_b       = {b ^ m_lfsr[1], m_lfsr[1]};
                m_r       = m_lfsr[2];
                m_plain_a = a;
                m_plain_b = b;
                m_valid   = 1'b1;
                m_lfsr    = prng_next(prng_next(prng_next(m_lfsr)));
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_output("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check_output("port_a", {30'b0, port_a}, {30'b0, m_a});
        check_output("port_b", {30'b0, port_b}, {30'b0, m_b});
        check_output("port_r", {31'b0, port_r}, {31'b0, m_r});
        check_output("lfsr_state", dut.lfsr_state, m_lfsr);
        if (m_valid) begin
            check_output("unmask_a", {31'b0, port_a[0] ^ port_a[1]}, {31'b0, m_plain_a});
            check_output("unmask_b", {31'b0, port_b[0] ^ port_b[1]}, {31'b0, m_plain_b});
        end
    endtask

    initial begin
        m_lfsr      = SEED;
        m_since     = 0;
        m_valid     = 1'b0;
        m_a         = 2'b00;
        m_b         = 2'b00;
        m_r         = 1'b0;
        m_plain_a   = 1'b0;
        m_plain_b   = 1'b0;
        cyc         = 0;
        first_ready = -1;

        $display("[TB] reset and warm-up with in_valid held high");
        apply_stimulus(1, 0, 0, 0, 1, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 1, 0, 32'h0);
        for (int i = 0; i < WARMUP + 6; i++)
            apply_stimulus(0, 1, 1'($urandom), 1'($urandom), 1, 0, 32'h0);
        check_output("first_ready_cycle", first_ready, WARMUP);

        $display("[TB] stream all four operand pairs");
        for (int i = 0; i < 8; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            apply_stimulus(0, 1, ab[0], ab[1], 1, 0, 32'h0);
        end

        $display("[TB] random traffic with back-pressure");
        for (int i = 0; i < 60; i++)
            apply_stimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 32'h0);

        $display("[TB] five-cycle stall then resume");
        apply_stimulus(0, 1, 1, 0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++)
            apply_stimulus(0, 1, 1'($urandom), 1'($urandom), 0, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 1, 1'($urandom), 1'($urandom), 1, 0, 32'h0);

        $display("[TB] reset pulse with an item pending");
        apply_stimulus(0, 1, 0, 1, 0, 0, 32'h0);
        apply_stimulus(1, 1, 1, 1, 0, 0, 32'h0);
        for (int i = 0; i < WARMUP + 10; i++)
            apply_stimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 32'h0);

`ifdef DOM_MASK_FEEDER_RESEED_EN
        $display("[TB] reseed with SEED while the register holds SEED");
        apply_stimulus(1, 0, 0, 0, 1, 0, 32'h0);
        apply_stimulus(0, 1, 0, 0, 1, 1, SEED);
        for (int i = 0; i < WARMUP + 4; i++)
            apply_stimulus(0, 1, 1'($urandom), 1'($urandom), 1, 0, 32'h0);

        $display("[TB] reseed during run with a pending item and in_valid high");
        apply_stimulus(0, 1, 1, 1, 0, 0, 32'h0);
        apply_stimulus(0, 1, 0, 1, 0, 1, $urandom);
        for (int i = 0; i < WARMUP + 8; i++)
            apply_stimulus(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
